eth_fcs_check_arb: RTL and testbench
====================================

Name: eth_fcs_check_arb

Overview:
- Frame-level round-robin scheduler sharing one 8-bit AXI-Stream Ethernet FCS checker between N MAC receive streams.
- Muxes whole frames into the checker and records the owner of each frame in a route FIFO, because the checker holds up to 4 bytes in flight.
- Steers checker output frames back to the owning port.
- Keeps per-port saturating bad-FCS counters from the checker's error pulse.

Parameters:
- PORTS, 4, number of requesting streams (2..16).
- ROUTE_DEPTH, 4, route FIFO entries (power of 2, ≥2); limits frames admitted to the checker but not yet fully drained.
- CNT_WIDTH, 16, width of each bad-FCS counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_axis_tdata  in  PORTS*8  per-port frame data, port i at [8i+7:8i]
- s_axis_tvalid  in  PORTS  per-port valid
- s_axis_tready  out  PORTS  per-port ready
- s_axis_tlast  in  PORTS  per-port last
- s_axis_tuser  in  PORTS  per-port error-in
- ck_in_tdata/tvalid/tlast/tuser  out  8/1/1/1  stream to checker
- ck_in_tready  in  1  checker ready
- ck_out_tdata/tvalid/tlast/tuser  in  8/1/1/1  stream from checker
- ck_out_tready  out  1  ready to checker
- ck_error_bad_fcs  in  1  checker bad-FCS pulse
- m_axis_tdata  out  PORTS*8  per-port checked data
- m_axis_tvalid  out  PORTS  per-port valid
- m_axis_tready  in  PORTS  per-port ready
- m_axis_tlast  out  PORTS  per-port last
- m_axis_tuser  out  PORTS  per-port error (tuser=1 on last = bad frame)
- bad_fcs_count  out  PORTS*CNT_WIDTH  per-port saturating counters
- busy  out  1  input FSM in ACTIVE or route FIFO non-empty

Behaviour:
- Reset (rst_n=0 at clk edge):
  - FSM←IDLE, rr pointer←PORTS-1, route FIFO emptied, counters←0, err_port_pending←0.
  - All s_axis_tready, ck_in_tvalid, ck_out_tready, m_axis_tvalid, busy = 0.
  - Reset mid-frame abandons the frame; the checker shares the same reset.
- Input FSM IDLE:
  - All s_axis_tready=0 and ck_in_tvalid=0.
  - If any s_axis_tvalid and route FIFO not full: grant the first requesting port scanning upward (mod PORTS) from rr+1; register grant_reg; push grant into route FIFO; go ACTIVE.
  - This gives a 1-cycle arbitration bubble per frame.
  - If the FIFO is full, stay IDLE.
- Input FSM ACTIVE:
  - ck_in_* = s_axis_*[grant_reg] combinationally.
  - s_axis_tready[grant_reg] = ck_in_tready; all other readies are 0.
  - On a handshake with tlast: rr←grant_reg, latch err_port←grant_reg, set err_port_pending for the next cycle, go IDLE.
  - Grant is never changed mid-frame.
- Output steering (zero latency, combinational):
  - When the route FIFO is non-empty with head h: m_axis_*[h] = ck_out_*, ck_out_tready = m_axis_tready[h], and m_axis_tvalid of every other port = 0.
  - When the route FIFO is empty: ck_out_tready=0 and all m_axis_tvalid=0.
  - Pop the FIFO on ck_out handshake with tlast.
  - Push and pop in the same cycle are allowed, including when the FIFO is full (pop frees the slot only next cycle; the full check uses the registered count).
- Error accounting:
  - The checker pulses ck_error_bad_fcs exactly one cycle after the input tlast handshake.
  - If ck_error_bad_fcs && err_port_pending: bad_fcs_count[err_port]++, saturating at all-ones.
  - err_port_pending clears every cycle it is not re-set.
  - A pulse without pending is ignored.
- Input constraints:
  - Input frames must be ≥5 bytes; shorter frames are unsupported.
  - Upstream tuser passes through untouched.
- Fairness: a continuously requesting port waits at most PORTS-1 frames.
- m_axis_tdata/tlast/tuser on non-selected ports are don't-care (driven 0).

Test Plan:
- Single frame: port 2 sends 64-byte frame with valid FCS, PORTS=4 → checker receives all 64 bytes; m_axis port 2 gets the 60-byte output, last tuser=0; other ports tvalid never 1; bad_fcs_count all 0.
- Round-robin: ports 0,1,3 continuously send 10-byte frames → grant order 0,1,3,0,1,3; one idle cycle on ck_in between frames.
- Bad FCS attribution: port 1 frame with corrupted FCS byte, then port 3 good frame back-to-back → bad_fcs_count[1]=1, count[3]=0; port 1 output last tuser=1.
- Route FIFO backpressure: hold m_axis_tready[0]=0; port 0 sends 6 short frames with ROUTE_DEPTH=4 → 4th admitted frame fills the FIFO; IDLE holds with s_axis_tready=0 until port 0 drains; no data is lost or misrouted.
- Saturation: CNT_WIDTH=2; 5 bad frames on port 0 → count 3 after the 3rd frame and stays 3.
- Reset mid-frame: rst_n=0 for 1 cycle during byte 20 of a port 2 frame → next cycle all ready/valid=0, counters 0; a subsequent frame on port 0 is granted (rr=PORTS-1 → port 0 first) and checked correctly.

Source files
------------

// File: rtl/eth_fcs_check_arb.sv
// eth_fcs_check_arb: round-robin frame mux of PORTS AXIS streams into one FCS checker; a route FIFO steers checked frames back; bad_fcs_count holds per-port saturating counts
module eth_fcs_check_arb #(
  parameter int PORTS       = 4,
  parameter int ROUTE_DEPTH = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PORTS*8-1:0]         s_axis_tdata,
  input  logic [PORTS-1:0]           s_axis_tvalid,
  output logic [PORTS-1:0]           s_axis_tready,
  input  logic [PORTS-1:0]           s_axis_tlast,
  input  logic [PORTS-1:0]           s_axis_tuser,
  output logic [7:0]                 ck_in_tdata,
  output logic                       ck_in_tvalid,
  output logic                       ck_in_tlast,
  output logic                       ck_in_tuser,
  input  logic                       ck_in_tready,
  input  logic [7:0]                 ck_out_tdata,
  input  logic                       ck_out_tvalid,
  input  logic                       ck_out_tlast,
  input  logic                       ck_out_tuser,
  output logic                       ck_out_tready,
  input  logic                       ck_error_bad_fcs,
  output logic [PORTS*8-1:0]         m_axis_tdata,
  output logic [PORTS-1:0]           m_axis_tvalid,
  input  logic [PORTS-1:0]           m_axis_tready,
  output logic [PORTS-1:0]           m_axis_tlast,
  output logic [PORTS-1:0]           m_axis_tuser,
  output logic [PORTS*CNT_WIDTH-1:0] bad_fcs_count,
  output logic                       busy
);
  localparam int PW = PORTS > 1 ? $clog2(PORTS) : 1;
  localparam int AW = $clog2(ROUTE_DEPTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] rr, grant_reg, grant_nx, idx, err_port, head;
  logic [PW-1:0] route_mem [ROUTE_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [CNT_WIDTH-1:0] cnt [PORTS];
  logic found, full, empty, push, pop, in_last_hs, err_port_pending;
  assign full  = count == (AW+1)'(ROUTE_DEPTH);
  assign empty = count == '0;
  assign head  = route_mem[rd_ptr];
  assign busy  = state == ACTIVE || !empty;
  always_comb begin
    found = 1'b0;
    grant_nx = rr;
    idx = rr;
    for (int k = 1; k <= PORTS; k++) begin
      idx = PW'((int'(rr) + k) % PORTS);
      if (!found && s_axis_tvalid[idx]) begin
        found = 1'b1;
        grant_nx = idx;
      end
    end
  end
  always_comb begin
    state_nx = state;
    push = 1'b0;
    in_last_hs = 1'b0;
    s_axis_tready = '0;
    ck_in_tdata = '0;
    ck_in_tvalid = 1'b0;
    ck_in_tlast = 1'b0;
    ck_in_tuser = 1'b0;
    if (state == IDLE) begin
      push = found && !full;
      state_nx = push ? ACTIVE : IDLE;
    end else begin
      ck_in_tdata = s_axis_tdata[{grant_reg, 3'b000} +: 8];
      ck_in_tvalid = s_axis_tvalid[grant_reg];
      ck_in_tlast = s_axis_tlast[grant_reg];
      ck_in_tuser = s_axis_tuser[grant_reg];
      s_axis_tready[grant_reg] = ck_in_tready;
      in_last_hs = ck_in_tvalid && ck_in_tready && ck_in_tlast;
      state_nx = in_last_hs ? IDLE : ACTIVE;
    end
  end
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tvalid = '0;
    m_axis_tlast = '0;
    m_axis_tuser = '0;
    ck_out_tready = 1'b0;
    if (!empty) begin
      m_axis_tdata[{head, 3'b000} +: 8] = ck_out_tdata;
      m_axis_tvalid[head] = ck_out_tvalid;
      m_axis_tlast[head] = ck_out_tlast;
      m_axis_tuser[head] = ck_out_tuser;
      ck_out_tready = m_axis_tready[head];
    end
  end
  assign pop = !empty && ck_out_tvalid && ck_out_tready && ck_out_tlast;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rr <= PW'(PORTS - 1);
      grant_reg <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      err_port <= '0;
      err_port_pending <= 1'b0;
      for (int i = 0; i < PORTS; i++) cnt[i] <= '0;
    end else begin
      state <= state_nx;
      if (push) begin
        grant_reg <= grant_nx;
        route_mem[wr_ptr] <= grant_nx;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      err_port_pending <= in_last_hs;
      if (in_last_hs) begin
        rr <= grant_reg;
        err_port <= grant_reg;
      end
      if (ck_error_bad_fcs && err_port_pending && cnt[err_port] != '1) cnt[err_port] <= cnt[err_port] + 1'b1;
    end
  end
  for (genvar g = 0; g < PORTS; g++) begin : g_cnt
    assign bad_fcs_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
  end
endmodule

// File: tb/tb_eth_fcs_check_arb.sv
// tb_eth_fcs_check_arb: scoreboard bench with a store-and-forward FCS checker model
module tb_eth_fcs_check_arb;
  localparam int P = 4, RD = 4, CW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [P*8-1:0] s_axis_tdata = '0, m_axis_tdata;
  logic [P-1:0] s_axis_tvalid = '0, s_axis_tready, s_axis_tlast = '0, s_axis_tuser = '0;
  logic [P-1:0] m_axis_tvalid, m_axis_tready = '0, m_axis_tlast, m_axis_tuser;
  logic [7:0] ck_in_tdata, ck_out_tdata = '0;
  logic ck_in_tvalid, ck_in_tlast, ck_in_tuser, ck_in_tready = 1'b1;
  logic ck_out_tvalid = 1'b0, ck_out_tlast = 1'b0, ck_out_tuser = 1'b0, ck_out_tready;
  logic ck_error_bad_fcs = 1'b0, busy;
  logic [P*CW-1:0] bad_fcs_count;
  eth_fcs_check_arb #(.PORTS(P), .ROUTE_DEPTH(RD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .ck_in_tdata(ck_in_tdata), .ck_in_tvalid(ck_in_tvalid), .ck_in_tlast(ck_in_tlast),
    .ck_in_tuser(ck_in_tuser), .ck_in_tready(ck_in_tready),
    .ck_out_tdata(ck_out_tdata), .ck_out_tvalid(ck_out_tvalid), .ck_out_tlast(ck_out_tlast),
    .ck_out_tuser(ck_out_tuser), .ck_out_tready(ck_out_tready), .ck_error_bad_fcs(ck_error_bad_fcs),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .bad_fcs_count(bad_fcs_count), .busy(busy)
  );
  typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
  beat_t src_q [P][$];
  beat_t exp_q [P][$];
  beat_t ck_q[$], ck_out_q[$];
  logic [P-1:0] snk_rdy = '1;
  int n_cmp = 0, n_bad = 0, cyc = 0, last_end = -1;
  int grant_log[$], gap_log[$], len_log[$];
  bit in_frame = 1'b0;
  always @(negedge clk) begin
    for (int p = 0; p < P; p++) begin
      s_axis_tvalid[p] = src_q[p].size() > 0;
      s_axis_tdata[p*8 +: 8] = s_axis_tvalid[p] ? src_q[p][0].d : 8'h00;
      s_axis_tlast[p] = s_axis_tvalid[p] ? src_q[p][0].l : 1'b0;
      s_axis_tuser[p] = s_axis_tvalid[p] ? src_q[p][0].u : 1'b0;
      m_axis_tready[p] = snk_rdy[p];
    end
  end
  always @(posedge clk) begin : model
    logic [7:0] x;
    bit bad, usr;
    int n;
    beat_t e;
    cyc++;
    if (!rst_n) begin
      ck_q.delete();
      ck_out_q.delete();
      in_frame = 1'b0;
      last_end = -1;
      ck_out_tvalid <= 1'b0;
      ck_out_tlast <= 1'b0;
      ck_out_tuser <= 1'b0;
      ck_out_tdata <= '0;
      ck_error_bad_fcs <= 1'b0;
    end else begin
      for (int p = 0; p < P; p++)
        if (s_axis_tvalid[p] && s_axis_tready[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
      ck_error_bad_fcs <= 1'b0;
      if (ck_in_tvalid && ck_in_tready) begin
        if (!in_frame) begin
          for (int p = 0; p < P; p++) if (s_axis_tready[p]) grant_log.push_back(p);
          if (last_end >= 0) gap_log.push_back(cyc - last_end);
          in_frame = 1'b1;
        end
        ck_q.push_back('{ck_in_tdata, ck_in_tlast, ck_in_tuser});
        if (ck_in_tlast) begin
          n = ck_q.size();
          len_log.push_back(n);
          x = 8'h00;
          usr = 1'b0;
          for (int i = 0; i < n; i++) usr |= ck_q[i].u;
          for (int i = 0; i < n - 4; i++) x ^= ck_q[i].d;
          bad = 1'b0;
          for (int i = n - 4; i < n; i++) if (ck_q[i].d != x) bad = 1'b1;
          for (int i = 0; i < n - 4; i++) ck_out_q.push_back('{ck_q[i].d, i == n - 5, (i == n - 5) && (bad || usr)});
          ck_error_bad_fcs <= bad;
          ck_q.delete();
          in_frame = 1'b0;
          last_end = cyc;
        end
      end
      if (ck_out_tvalid && ck_out_tready && ck_out_q.size() > 0) void'(ck_out_q.pop_front());
      ck_out_tvalid <= ck_out_q.size() > 0;
      ck_out_tdata <= ck_out_q.size() > 0 ? ck_out_q[0].d : 8'h00;
      ck_out_tlast <= ck_out_q.size() > 0 ? ck_out_q[0].l : 1'b0;
      ck_out_tuser <= ck_out_q.size() > 0 ? ck_out_q[0].u : 1'b0;
      for (int p = 0; p < P; p++) begin
        if (m_axis_tvalid[p] && exp_q[p].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_valid port %0d: tvalid=1 with no frame expected", p);
        end else if (m_axis_tvalid[p] && m_axis_tready[p]) begin
          e = exp_q[p].pop_front();
          n_cmp++;
          if ({m_axis_tdata[p*8 +: 8], m_axis_tlast[p], m_axis_tuser[p]} !== e) begin
            n_bad++;
            $display("FAIL out_beat port %0d: got d=%h l=%b u=%b want d=%h l=%b u=%b", p,
                     m_axis_tdata[p*8 +: 8], m_axis_tlast[p], m_axis_tuser[p], e.d, e.l, e.u);
          end
        end
      end
    end
  end
  task automatic send_frame(input int p, input int len, input bit bad, input bit usr);
    logic [7:0] b [$];
    logic [7:0] x = 8'h00;
    for (int i = 0; i < len - 4; i++) begin
      b.push_back(8'($urandom_range(0, 255)));
      x ^= b[i];
    end
    for (int i = 0; i < 4; i++) b.push_back(x);
    if (bad) b[len - 1] = ~x;
    for (int i = 0; i < len; i++) src_q[p].push_back('{b[i], i == len - 1, usr && i == len - 1});
    for (int i = 0; i < len - 4; i++) exp_q[p].push_back('{b[i], i == len - 5, (i == len - 5) && (bad || usr)});
  endtask
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic wait_drain(input string name);
    int t = 0;
    bit pend = 1'b1;
    while (pend && t < 3000) begin
      @(negedge clk);
      t++;
      pend = busy || ck_out_q.size() > 0 || ck_q.size() > 0;
      for (int p = 0; p < P; p++) pend |= src_q[p].size() > 0 || exp_q[p].size() > 0;
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pend) begin
      n_bad++;
      $display("FAIL drain_%s: traffic still pending after %0d cycles, want drained", name, t);
    end
  endtask
  task automatic check_cnt(input string name, input int p, input int want);
    n_cmp++;
    if (bad_fcs_count[p*CW +: CW] !== CW'(want)) begin
      n_bad++;
      $display("FAIL %s: bad_fcs_count[%0d]=%0d want %0d", name, p, bad_fcs_count[p*CW +: CW], want);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({s_axis_tready, ck_in_tvalid, ck_out_tready, m_axis_tvalid, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b ckv=%b ckr=%b mv=%b busy=%b want all 0",
               s_axis_tready, ck_in_tvalid, ck_out_tready, m_axis_tvalid, busy);
    end
    n_cmp++;
    if (bad_fcs_count !== '0) begin
      n_bad++;
      $display("FAIL reset_counts: got %h want 0", bad_fcs_count);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_single();
    grant_log.delete();
    len_log.delete();
    send_frame(2, 64, 1'b0, 1'b0);
    wait_drain("single");
    n_cmp++;
    if (grant_log.size() != 1 || grant_log[0] != 2 || len_log.size() != 1 || len_log[0] != 64) begin
      n_bad++;
      $display("FAIL single_grant: grants=%0d len=%0d want port 2 len 64", grant_log.size(), len_log.size() ? len_log[0] : 0);
    end
    for (int p = 0; p < P; p++) check_cnt("single_cnt", p, 0);
  endtask
  task automatic test_round_robin();
    int want [6] = '{0, 1, 3, 0, 1, 3};
    apply_reset();
    grant_log.delete();
    gap_log.delete();
    for (int k = 0; k < 2; k++) begin
      send_frame(0, 10, 1'b0, 1'b0);
      send_frame(1, 10, 1'b0, 1'b0);
      send_frame(3, 10, 1'b0, 1'b0);
    end
    wait_drain("rr");
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (i >= grant_log.size() || grant_log[i] != want[i]) begin
        n_bad++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", i, i < grant_log.size() ? grant_log[i] : -1, want[i]);
      end
    end
    n_cmp++;
    if (gap_log.size() != 5 || gap_log.min() != '{2} || gap_log.max() != '{2}) begin
      n_bad++;
      $display("FAIL rr_gap: %0d gaps, want 5 gaps of exactly 2 cycles", gap_log.size());
    end
  endtask
  task automatic test_bad_fcs();
    apply_reset();
    send_frame(1, 12, 1'b1, 1'b0);
    send_frame(3, 12, 1'b0, 1'b0);
    send_frame(2, 9, 1'b0, 1'b1);
    wait_drain("bad");
    check_cnt("bad_cnt1", 1, 1);
    check_cnt("bad_cnt3", 3, 0);
    check_cnt("bad_cnt2", 2, 0);
    check_cnt("bad_cnt0", 0, 0);
  endtask
  task automatic test_backpressure();
    apply_reset();
    grant_log.delete();
    snk_rdy[0] = 1'b0;
    for (int k = 0; k < 6; k++) send_frame(0, 6, 1'b0, 1'b0);
    repeat (80) @(negedge clk);
    #1;
    n_cmp++;
    if (grant_log.size() != RD || s_axis_tready[0] !== 1'b0 || s_axis_tvalid[0] !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_hold: admitted=%0d rdy=%b busy=%b want admitted=%0d rdy=0 busy=1",
               grant_log.size(), s_axis_tready[0], busy, RD);
    end
    snk_rdy[0] = 1'b1;
    wait_drain("bp");
    n_cmp++;
    if (grant_log.size() != 6) begin
      n_bad++;
      $display("FAIL bp_total: admitted=%0d want 6", grant_log.size());
    end
  endtask
  task automatic test_saturation();
    apply_reset();
    for (int k = 1; k <= 5; k++) begin
      send_frame(0, 6, 1'b1, 1'b0);
      wait_drain("sat");
      check_cnt("sat_cnt", 0, k < 3 ? k : 3);
    end
  endtask
  task automatic test_reset_mid_frame();
    int t = 0;
    send_frame(2, 40, 1'b0, 1'b0);
    while (src_q[2].size() > 20 && t < 300) begin
      @(negedge clk);
      t++;
    end
    rst_n = 1'b0;
    src_q[2].delete();
    exp_q[2].delete();
    @(negedge clk);
    #1;
    n_cmp++;
    if ({s_axis_tready, ck_in_tvalid, ck_out_tready, m_axis_tvalid, busy} !== '0 || bad_fcs_count !== '0 || t >= 300) begin
      n_bad++;
      $display("FAIL midrst: rdy=%b ckv=%b mv=%b busy=%b cnt=%h waited=%0d want all 0",
               s_axis_tready, ck_in_tvalid, m_axis_tvalid, busy, bad_fcs_count, t);
    end
    rst_n = 1'b1;
    grant_log.delete();
    send_frame(2, 8, 1'b0, 1'b0);
    send_frame(0, 8, 1'b1, 1'b0);
    wait_drain("midrst");
    n_cmp++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 2) begin
      n_bad++;
      $display("FAIL midrst_order: first=%0d n=%0d want port 0 then 2", grant_log.size() ? grant_log[0] : -1, grant_log.size());
    end
    check_cnt("midrst_cnt0", 0, 1);
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_bad_fcs();
    test_backpressure();
    test_saturation();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
